// File: rtl/lut_lookup_arbiter_pkg.sv
// lut_lookup_arbiter_pkg
//   Shared definitions for the lookup arbiter:
//   - state_e        : two-state sequencer (IDLE / RESP)
//   - entry_t        : table entry layout {en, key, data} at the default widths
//   - rr_next_grant  : round-robin pick of the first valid requester at or
//                      after a pointer, in circular order
package lut_lookup_arbiter_pkg;

   localparam int LUT_KEY_LEN  = 8;
   localparam int LUT_DATA_LEN = 32;
   // Upper bound on requesters supported by rr_next_grant.
   localparam int MAX_REQ      = 32;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RESP = 1'b1
   } state_e;

   typedef struct packed {
      logic                    en;
      logic [LUT_KEY_LEN-1:0]  key;
      logic [LUT_DATA_LEN-1:0] data;
   } entry_t;

   // Returns the first index with valid set, scanning ptr, ptr+1, ... modulo nr.
   // When nothing is valid it returns ptr; callers qualify with |valid.
   function automatic int rr_next_grant(input logic [MAX_REQ-1:0] valid,
                                        input int ptr,
                                        input int nr);
      int sel;
      int idx;
      bit found;
      sel   = ptr;
      found = 1'b0;
      for (int k = 0; k < MAX_REQ; k++) begin
         if (k < nr && !found) begin
            idx = ptr + k;
            if (idx >= nr)
               idx = idx - nr;
            if (valid[idx[4:0]]) begin
               sel   = idx;
               found = 1'b1;
            end
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/lut_lookup_arbiter_if.sv
// lut_lookup_arbiter_if
//   Request/response bundle between requesters and the lookup arbiter.
//   req_valid/req_key/req_ready : per-requester lookup request handshake
//   rsp_valid/rsp_ready         : per-requester response handshake
//   rsp_data/rsp_hit            : shared response payload (owner = rsp_valid bit)
//   master modport: requester side; slave modport: arbiter side.
interface lut_lookup_arbiter_if #(
   parameter int NR_REQ   = 2,
   parameter int KEY_LEN  = 8,
   parameter int DATA_LEN = 32
);
   logic [NR_REQ-1:0]         req_valid;
   logic [NR_REQ*KEY_LEN-1:0] req_key;
   logic [NR_REQ-1:0]         req_ready;
   logic [NR_REQ-1:0]         rsp_valid;
   logic [NR_REQ-1:0]         rsp_ready;
   logic [DATA_LEN-1:0]       rsp_data;
   logic                      rsp_hit;

   modport master (
      output req_valid, req_key, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_hit
   );

   modport slave (
      input  req_valid, req_key, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_hit
   );
endinterface

// File: rtl/lut_lookup_arbiter_match.sv
// lut_match
//   Purely combinational table match.
//   Ports: en/key_tbl/data_tbl (table contents), key (lookup key)
//          -> hit (any valid entry matched), data (data of lowest matching index,
//             zero when no match; the caller applies its own default).
module lut_match #(
   parameter int NR_KEY   = 4,
   parameter int KEY_LEN  = 8,
   parameter int DATA_LEN = 32
) (
   input  logic [NR_KEY-1:0]   en,
   input  logic [KEY_LEN-1:0]  key_tbl  [NR_KEY],
   input  logic [DATA_LEN-1:0] data_tbl [NR_KEY],
   input  logic [KEY_LEN-1:0]  key,
   output logic                hit,
   output logic [DATA_LEN-1:0] data
);

   logic [NR_KEY-1:0] hit_vec;

   for (genvar gi = 0; gi < NR_KEY; gi++) begin : g_cmp
      assign hit_vec[gi] = en[gi] && (key_tbl[gi] == key);
   end

   // Scan from the top down so the lowest matching index is the last write
   // and therefore wins; data is selected, never OR-combined.
   always_comb begin
      data = '0;
      for (int i = NR_KEY - 1; i >= 0; i--) begin
         if (hit_vec[i])
            data = data_tbl[i];
      end
   end

   assign hit = |hit_vec;

endmodule

// File: rtl/lut_lookup_arbiter.sv
// lut_lookup_arbiter
//   Runtime-programmable key->data lookup shared by NR_REQ requesters.
//   Ports: clk, rst_n (sync, active-low)
//          cfg_we/cfg_idx/cfg_en/cfg_key/cfg_data : table write port
//          default_data : miss data, captured when a request is accepted
//          bus (slave)  : request/response handshakes and response payload
//   Round-robin grant in IDLE, or chained on the response handshake in RESP;
//   each accepted request yields one registered response.
module lut_lookup_arbiter
   import lut_lookup_arbiter_pkg::*;
#(
   parameter int NR_REQ   = 2,
   parameter int NR_KEY   = 4,
   parameter int KEY_LEN  = LUT_KEY_LEN,
   parameter int DATA_LEN = LUT_DATA_LEN,
   localparam int IDX_W   = (NR_KEY > 1) ? $clog2(NR_KEY) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cfg_we,
   input  logic [IDX_W-1:0]     cfg_idx,
   input  logic                 cfg_en,
   input  logic [KEY_LEN-1:0]   cfg_key,
   input  logic [DATA_LEN-1:0]  cfg_data,
   input  logic [DATA_LEN-1:0]  default_data,
   lut_lookup_arbiter_if.slave  bus
);

   localparam int PTR_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

   state_e              state_reg, state_next;
   logic [PTR_W-1:0]    rr_ptr_reg, rr_ptr_next;
   logic [PTR_W-1:0]    owner_reg;
   logic [NR_REQ-1:0]   rsp_valid_reg;
   logic [DATA_LEN-1:0] rsp_data_reg;
   logic                rsp_hit_reg;

   logic [NR_KEY-1:0]   en_reg;
   logic [KEY_LEN-1:0]  key_mem  [NR_KEY];
   logic [DATA_LEN-1:0] data_mem [NR_KEY];

   logic [PTR_W-1:0]    grant_idx;
   logic [NR_REQ-1:0]   grant_oh;
   logic                grant;
   logic                rsp_done;
   logic                cfg_ok;
   logic [KEY_LEN-1:0]  lookup_key;
   logic                match_hit;
   logic [DATA_LEN-1:0] match_data;

   assign cfg_ok     = cfg_we && (int'(cfg_idx) < NR_KEY);
   assign grant_idx  = PTR_W'(rr_next_grant(MAX_REQ'(bus.req_valid), int'(rr_ptr_reg), NR_REQ));
   assign lookup_key = bus.req_key[int'(grant_idx)*KEY_LEN +: KEY_LEN];
   // Only the owner's rsp_ready completes a response.
   assign rsp_done   = (state_reg == ST_RESP) && bus.rsp_ready[owner_reg];

   // The match sees the registered table, so a write in the grant cycle
   // only takes effect for later lookups.
   lut_match #(
      .NR_KEY   (NR_KEY),
      .KEY_LEN  (KEY_LEN),
      .DATA_LEN (DATA_LEN)
   ) u_match (
      .en       (en_reg),
      .key_tbl  (key_mem),
      .data_tbl (data_mem),
      .key      (lookup_key),
      .hit      (match_hit),
      .data     (match_data)
   );

   always_comb begin
      state_next  = state_reg;
      rr_ptr_next = rr_ptr_reg;
      grant       = 1'b0;
      grant_oh    = '0;
      // Accept when idle, or chain onto the response handshake in RESP.
      if (rst_n && (|bus.req_valid) && (state_reg == ST_IDLE || rsp_done)) begin
         grant              = 1'b1;
         grant_oh[grant_idx] = 1'b1;
         state_next         = ST_RESP;
         rr_ptr_next        = (int'(grant_idx) == NR_REQ - 1) ? '0 : grant_idx + PTR_W'(1);
      end else if (rsp_done) begin
         state_next = ST_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= ST_IDLE;
         rr_ptr_reg    <= '0;
         owner_reg     <= '0;
         rsp_valid_reg <= '0;
         rsp_data_reg  <= '0;
         rsp_hit_reg   <= 1'b0;
         en_reg        <= '0;
      end else begin
         state_reg  <= state_next;
         rr_ptr_reg <= rr_ptr_next;
         if (grant) begin
            owner_reg     <= grant_idx;
            rsp_valid_reg <= grant_oh;
            rsp_data_reg  <= match_hit ? match_data : default_data;
            rsp_hit_reg   <= match_hit;
         end else if (rsp_done) begin
            rsp_valid_reg <= '0;
         end
         if (cfg_ok)
            en_reg[cfg_idx] <= cfg_en;
      end
   end

   // Key/data contents are only meaningful behind en_reg, so they carry no reset.
   always_ff @(posedge clk) begin
      if (cfg_ok) begin
         key_mem[cfg_idx]  <= cfg_key;
         data_mem[cfg_idx] <= cfg_data;
      end
   end

   assign bus.req_ready = grant_oh;
   assign bus.rsp_valid = rsp_valid_reg;
   assign bus.rsp_data  = rsp_data_reg;
   assign bus.rsp_hit   = rsp_hit_reg;

endmodule

// File: tb/tb_lut_lookup_arbiter.sv
// tb_lut_lookup_arbiter
//   Directed bench for lut_lookup_arbiter (NR_REQ=2, NR_KEY=4, 8-bit keys,
//   32-bit data). Inputs change 1 time unit after the rising edge; outputs are
//   checked 2 time units after the edge.
module tb_lut_lookup_arbiter;
   import lut_lookup_arbiter_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        cfg_we;
   logic [1:0]  cfg_idx;
   logic        cfg_en;
   logic [7:0]  cfg_key;
   logic [31:0] cfg_data;
   logic [31:0] default_data;

   int n_chk;
   int n_bad;

   lut_lookup_arbiter_if #(.NR_REQ(2), .KEY_LEN(8), .DATA_LEN(32)) bus ();

   lut_lookup_arbiter #(
      .NR_REQ   (2),
      .NR_KEY   (4),
      .KEY_LEN  (8),
      .DATA_LEN (32)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cfg_we       (cfg_we),
      .cfg_idx      (cfg_idx),
      .cfg_en       (cfg_en),
      .cfg_key      (cfg_key),
      .cfg_data     (cfg_data),
      .default_data (default_data),
      .bus          (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cfg_write(input int idx, input entry_t e);
      cfg_idx  = 2'(idx);
      cfg_en   = e.en;
      cfg_key  = e.key;
      cfg_data = e.data;
      cfg_we   = 1'b1;
      @(posedge clk); #1;
      cfg_we   = 1'b0;
      $display("cfg idx=%0d en=%0d key=0x%02h data=0x%08h", idx, e.en, e.key, e.data);
   endtask

   // Single request from requester r, starting from IDLE.
   task automatic do_lookup(input int r, input logic [7:0] key, input logic [31:0] dflt,
                            input logic exp_hit, input logic [31:0] exp_data, input string tag);
      logic [1:0] oh;
      oh = 2'b01 << r;
      bus.req_valid = oh;
      bus.req_key[r*8 +: 8] = key;
      default_data = dflt;
      #1;
      chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'(oh));
      @(posedge clk); #1;
      bus.req_valid = '0;
      default_data  = ~dflt;   // response must keep the default captured at acceptance
      #1;
      chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'(oh));
      chk({tag, "_rsp_hit"},   64'(bus.rsp_hit),   64'(exp_hit));
      chk({tag, "_rsp_data"},  64'(bus.rsp_data),  64'(exp_data));
      $display("lookup %s req=%0d key=0x%02h hit=%0d data=0x%08h", tag, r, key, bus.rsp_hit, bus.rsp_data);
      bus.rsp_ready = oh;
      @(posedge clk); #1;
      bus.rsp_ready = '0;
      #1;
      chk({tag, "_rsp_done"}, 64'(bus.rsp_valid), 64'd0);
   endtask

   initial begin
      n_chk = 0;
      n_bad = 0;
      rst_n = 1'b0;
      cfg_we = 1'b0; cfg_idx = '0; cfg_en = 1'b0; cfg_key = '0; cfg_data = '0;
      default_data = 32'h0;
      bus.req_valid = 2'b01;
      bus.req_key   = '0;
      bus.rsp_ready = '0;

      // Reset state; req_ready must stay low while reset is held.
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
      chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("rst_rsp_data",  64'(bus.rsp_data),  64'd0);
      chk("rst_rsp_hit",   64'(bus.rsp_hit),   64'd0);
      bus.req_valid = '0;
      rst_n = 1'b1;

      // Empty table: miss returns the default.
      do_lookup(0, 8'h12, 32'h0000DEAD, 1'b0, 32'h0000DEAD, "t1_miss");

      // Lowest matching index wins.
      cfg_write(1, '{en: 1'b1, key: 8'h12, data: 32'h0000CAFE});
      cfg_write(3, '{en: 1'b1, key: 8'h12, data: 32'h0000BEEF});
      do_lookup(0, 8'h12, 32'h0000DEAD, 1'b1, 32'h0000CAFE, "t2_lowidx");
      do_lookup(0, 8'h34, 32'h0000DEAD, 1'b0, 32'h0000DEAD, "t2_miss34");
      cfg_write(1, '{en: 1'b0, key: 8'h12, data: 32'h0000CAFE});
      cfg_write(2, '{en: 1'b1, key: 8'h34, data: 32'h00003434});
      // Uses requester 1 so the round-robin pointer returns to 0.
      do_lookup(1, 8'h12, 32'h0000DEAD, 1'b1, 32'h0000BEEF, "t2_disabled");

      // Both requesters valid, continuous rsp_ready: alternating grants, one per cycle.
      bus.req_key   = {8'h34, 8'h12};
      bus.req_valid = 2'b11;
      bus.rsp_ready = 2'b11;
      #1;
      chk("t3_first_grant", 64'(bus.req_ready), 64'(2'b01));
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #2;
         chk($sformatf("t3_c%0d_rsp_valid", k), 64'(bus.rsp_valid), (k % 2 == 0) ? 64'd1 : 64'd2);
         chk($sformatf("t3_c%0d_rsp_data", k),  64'(bus.rsp_data),
             (k % 2 == 0) ? 64'h0000BEEF : 64'h00003434);
         chk($sformatf("t3_c%0d_rsp_hit", k),   64'(bus.rsp_hit), 64'd1);
         chk($sformatf("t3_c%0d_req_ready", k), 64'(bus.req_ready), (k % 2 == 0) ? 64'd2 : 64'd1);
         $display("stream c%0d owner=%b data=0x%08h", k, bus.rsp_valid, bus.rsp_data);
      end

      // Owner is requester 1; stall it while requester 0 waits.
      bus.rsp_ready = 2'b00;
      #1;
      chk("t4_stall_req_ready", 64'(bus.req_ready), 64'd0);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         // One stall cycle drives only the non-owner's ready, which must be ignored.
         bus.rsp_ready = (k == 2) ? 2'b01 : 2'b00;
         #1;
         chk($sformatf("t4_s%0d_rsp_valid", k), 64'(bus.rsp_valid), 64'd2);
         chk($sformatf("t4_s%0d_rsp_data", k),  64'(bus.rsp_data),  64'h00003434);
         chk($sformatf("t4_s%0d_req_ready", k), 64'(bus.req_ready), 64'd0);
      end
      $display("stall held owner=%b data=0x%08h", bus.rsp_valid, bus.rsp_data);
      bus.rsp_ready = 2'b10;
      #1;
      chk("t4_chain_req_ready", 64'(bus.req_ready), 64'd1);
      @(posedge clk); #1;
      bus.req_valid = 2'b00;
      bus.rsp_ready = 2'b01;
      #1;
      chk("t4_chain_rsp_valid", 64'(bus.rsp_valid), 64'd1);
      chk("t4_chain_rsp_data",  64'(bus.rsp_data),  64'h0000BEEF);
      @(posedge clk); #1;
      bus.rsp_ready = 2'b00;
      #1;
      chk("t4_idle_rsp_valid", 64'(bus.rsp_valid), 64'd0);

      // Table write in the grant cycle does not affect that lookup.
      bus.req_valid = 2'b10;
      bus.req_key[15:8] = 8'h55;
      default_data = 32'h00000BAD;
      cfg_idx = 2'd0; cfg_en = 1'b1; cfg_key = 8'h55; cfg_data = 32'h00001111; cfg_we = 1'b1;
      #1;
      chk("t5_req_ready", 64'(bus.req_ready), 64'd2);
      @(posedge clk); #1;
      cfg_we = 1'b0;
      bus.req_valid = 2'b00;
      default_data = 32'h0;
      #1;
      chk("t5_same_rsp_valid", 64'(bus.rsp_valid), 64'd2);
      chk("t5_same_rsp_hit",   64'(bus.rsp_hit),   64'd0);
      chk("t5_same_rsp_data",  64'(bus.rsp_data),  64'h00000BAD);
      $display("lookup t5_same req=1 key=0x55 hit=%0d data=0x%08h", bus.rsp_hit, bus.rsp_data);
      bus.rsp_ready = 2'b10;
      @(posedge clk); #1;
      bus.rsp_ready = 2'b00;
      do_lookup(0, 8'h55, 32'h00000BAD, 1'b1, 32'h00001111, "t5_next");

      // Reset while a response is pending.
      bus.req_valid = 2'b01;
      bus.req_key[7:0] = 8'h55;
      @(posedge clk); #1;
      bus.req_valid = 2'b00;
      #1;
      chk("t6_pre_rsp_valid", 64'(bus.rsp_valid), 64'd1);
      chk("t6_pre_rsp_data",  64'(bus.rsp_data),  64'h00001111);
      rst_n = 1'b0;
      bus.req_valid = 2'b11;
      #1;
      chk("t6_rst_req_ready", 64'(bus.req_ready), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      bus.req_valid = 2'b00;
      #1;
      chk("t6_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("t6_rst_rsp_data",  64'(bus.rsp_data),  64'd0);
      chk("t6_rst_rsp_hit",   64'(bus.rsp_hit),   64'd0);
      do_lookup(0, 8'h55, 32'h0000ABCD, 1'b0, 32'h0000ABCD, "t6_miss55");
      do_lookup(1, 8'h12, 32'h00005678, 1'b0, 32'h00005678, "t6_miss12");

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/lut_lookup_arbiter.md
# lut_lookup_arbiter

Shared, runtime-programmable key→data lookup engine for several requesters, such as fetch-side and load/store-side region decode. It owns an NR_KEY-entry table written through a configuration port. It arbitrates lookup requests round-robin and returns one registered response per accepted request over a valid/ready handshake. Table matching is done by a combinational sub-module; this block adds storage, arbitration, sequencing and response buffering.

## Interface
- NR_REQ, 2, number of requesters (≥1)
- NR_KEY, 4, number of table entries (≥1)
- KEY_LEN, 8, key width
- DATA_LEN, 32, data width
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; one clock, synchronous, active-low
- cfg_we  in  1  table write strobe
- cfg_idx  in  $clog2(NR_KEY) (min 1)  entry index; values ≥ NR_KEY ignored
- cfg_en  in  1  entry valid bit to write
- cfg_key  in  KEY_LEN  entry key
- cfg_data  in  DATA_LEN  entry data
- default_data  in  DATA_LEN  data returned on miss; sampled at acceptance
- req_valid  in  NR_REQ  per-requester request valid
- req_key  in  NR_REQ*KEY_LEN  packed keys; requester i at [(i+1)*KEY_LEN-1 : i*KEY_LEN]
- req_ready  out  NR_REQ  one-hot or zero; asserted only for the granted requester
- rsp_valid  out  NR_REQ  one-hot or zero; response owner
- rsp_ready  in  NR_REQ  per-requester response ready
- rsp_data  out  DATA_LEN  hit data, or latched default on miss
- rsp_hit  out  1  1 = key matched a valid entry

## Operation
- Table: NR_KEY entries of {en, key, data}. A write with cfg_we=1 updates entry cfg_idx at the clock edge.
- Match: entry i hits when en[i] && key[i]==lookup key. On multiple hits, the lowest index wins; data is never OR-combined.
- FSM states: IDLE and RESP.
  - IDLE: if any req_valid, grant the first requester at or after rr_ptr in circular order.
  - In the same cycle, assert req_ready[g], evaluate the match on req_key[g], then register data, hit and owner g. Next state is RESP.
  - RESP: hold rsp_valid[g], rsp_data and rsp_hit stable until rsp_ready[g].
  - On that response handshake, the block may accept a new grant in the same cycle (chained). Next state is RESP if a new grant occurs, otherwise IDLE.
- rr_ptr becomes (g+1) mod NR_REQ on every grant. It does not change when nothing is granted.
- A requester that is not granted keeps req_valid and req_key stable until granted.
- A table write in the grant cycle does not affect that lookup; it uses the pre-edge table. Writes during RESP do not alter the already-latched response.
- rsp_ready of a non-owner is ignored.

## Timing
- Reset values:
  - state=IDLE, rr_ptr=0.
  - All en cleared; key and data contents are don't-care.
  - req_ready=0, rsp_valid=0, rsp_data=0, rsp_hit=0.
- req_ready is combinational from state, req_valid, rr_ptr and rsp_ready (chain case). It is never asserted while rst_n=0.
- Latency: a request accepted at edge T gives rsp_valid=1 in the cycle after T, and all response outputs come from flops.
- Throughput:
  - One lookup per cycle with continuous rsp_ready.
  - Without chaining, a gap of one IDLE cycle.
- rsp_ready=0 holds RESP indefinitely; no new grants are made.
- Reset mid-RESP discards the pending response. rsp_valid=0 in the cycle after reset is sampled low.
- NR_REQ=1: arbitration degenerates to pass-through and rr_ptr stays 0.

## Structure
- Shared package holds: the FSM state enum, the entry struct typedef {en, key, data} (parameterised by width), and a helper function for round-robin next-grant.
- One sub-module, lut_match. It is purely combinational: table in, key in → hit, priority-resolved data. It does not apply the default; this block muxes default_data.
- Arbiter, FSM and table registers live in lut_lookup_arbiter.

## Test plan
- After reset: no writes; req 0 valid, key 0x12, default 0xDEAD → rsp_valid=01 one cycle later, rsp_hit=0, rsp_data=0xDEAD.
- Program idx1={1,0x12,0xCAFE} and idx3={1,0x12,0xBEEF}; look up key 0x12 → rsp_hit=1, rsp_data=0xCAFE (lowest index wins). Clear en of idx1 → 0xBEEF.
- Both requesters are continuously valid with keys 0x12 and 0x34, and rsp_ready=11. Expected: grants alternate 0,1,0,1; one response per cycle; responses match each key.
- rsp_ready=0 for 5 cycles while the other requester is valid → outputs stay stable, req_ready=00. Raise rsp_ready → handshake, then the waiting requester is granted in that same cycle.
- cfg write to idx0={1,0x55,0x1111} in the same cycle a lookup of 0x55 is granted → miss (default). An identical lookup next → hit, 0x1111.
- Deassert rst_n during RESP → next cycle rsp_valid=00, state IDLE, all entries miss.
